// File: rtl/external_mem_responder.sv
// external_mem_responder
//   Responder for the regblock external req/ack interface. It models an external
//   register array or memory of DEPTH entries, each holding SUBWORDS lanes of
//   WIDTH bits. Every accepted request is acknowledged after a bounded
//   pseudo-random delay drawn from a 16-bit Galois LFSR. The delay is fixed when
//   MIN_DELAY == MAX_DELAY. Protocol violations by the requester raise a sticky
//   flag that clears only on reset.
//
// Ports
//   clk        clock
//   rst        synchronous, active-low reset
//   req        per-lane request strobe (single-cycle pulse); any set bit = request
//   req_addr   entry index
//   req_is_wr  1 = write, 0 = read
//   wr_data    write data, applied to every strobed lane
//   wr_biten   per-bit write enable
//   rd_ack     read response pulse (1 cycle)
//   rd_data    read data, zero whenever rd_ack is low
//   wr_ack     write response pulse (1 cycle)
//   busy       a request is outstanding (WAIT state)
//   proto_err  sticky protocol-violation flag (overlap or out-of-range address)
module external_mem_responder #(
  parameter int          WIDTH     = 32,
  parameter int          SUBWORDS  = 1,
  parameter int          DEPTH     = 16,
  parameter int          MIN_DELAY = 0,
  parameter int          MAX_DELAY = 3,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SUBWORDS-1:0] req,
  input  logic [AW-1:0]       req_addr,
  input  logic                req_is_wr,
  input  logic [WIDTH-1:0]    wr_data,
  input  logic [WIDTH-1:0]    wr_biten,
  output logic                rd_ack,
  output logic [WIDTH-1:0]    rd_data,
  output logic                wr_ack,
  output logic                busy,
  output logic                proto_err
);

  localparam int DELAY_SPAN = MAX_DELAY - MIN_DELAY + 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t state, next_state;

  logic [3:0]          cnt;
  logic [15:0]         lfsr;

  // Captured request
  logic [AW-1:0]       cap_addr;
  logic                cap_addr_ok;
  logic [SUBWORDS-1:0] cap_strb;
  logic                cap_wr;
  logic [WIDTH-1:0]    cap_data;
  logic [WIDTH-1:0]    cap_biten;

  logic [WIDTH-1:0]    mem [DEPTH][SUBWORDS];

  // Decoded control
  logic                accept;    // new request taken (IDLE or RESP)
  logic                drop;      // request arriving while one is outstanding
  logic                fire;      // last WAIT cycle: ack and commit at this edge
  logic                addr_ok;
  logic [3:0]          delay;
  logic [15:0]         lfsr_next;
  logic [AW-1:0]       mem_idx;   // clamped index, only used when cap_addr_ok
  logic [WIDTH-1:0]    rd_lane;

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned; otherwise a latch is inferred.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    drop       = 1'b0;
    fire       = 1'b0;
    unique case (state)
      IDLE: begin
        accept = |req;
        if (accept) next_state = WAIT;
      end
      WAIT: begin
        drop = |req;
        if (cnt == 4'd0) begin
          fire       = 1'b1;
          next_state = RESP;
        end
      end
      RESP: begin
        // Acts as IDLE for new requests, so back-to-back traffic is accepted.
        accept     = |req;
        next_state = accept ? WAIT : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    addr_ok   = (32'(req_addr) < DEPTH);
    // Delay uses the LFSR value before this request advances it.
    delay     = 4'(MIN_DELAY + (int'(lfsr[7:0]) % DELAY_SPAN));
    // Galois form of x^16 + x^14 + x^13 + x^11.
    lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
    mem_idx   = cap_addr_ok ? cap_addr : '0;
    // The highest-index strobed lane wins.
    rd_lane   = '0;
    for (int i = 0; i < SUBWORDS; i++) begin
      if (cap_strb[i]) rd_lane = mem[mem_idx][i];
    end
  end

  assign busy = (state == WAIT);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      lfsr        <= LFSR_SEED;
      cap_addr    <= '0;
      cap_addr_ok <= 1'b0;
      cap_strb    <= '0;
      cap_wr      <= 1'b0;
      cap_data    <= '0;
      cap_biten   <= '0;
      rd_ack      <= 1'b0;
      wr_ack      <= 1'b0;
      rd_data     <= '0;
      proto_err   <= 1'b0;
    end else begin
      state <= next_state;

      if (accept) begin
        cnt         <= delay;
        lfsr        <= lfsr_next;
        cap_addr    <= req_addr;
        cap_addr_ok <= addr_ok;
        cap_strb    <= req;
        cap_wr      <= req_is_wr;
        cap_data    <= wr_data;
        cap_biten   <= wr_biten;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end

      rd_ack  <= fire && !cap_wr;
      wr_ack  <= fire && cap_wr;
      rd_data <= (fire && !cap_wr && cap_addr_ok) ? rd_lane : '0;

      if (drop || (accept && !addr_ok)) proto_err <= 1'b1;
    end
  end

  // NOTE: the array is cleared on reset because the reset behaviour requires
  // reads after reset to return zero; this forces it into flops, not RAM.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int a = 0; a < DEPTH; a++) begin
        for (int i = 0; i < SUBWORDS; i++) mem[a][i] <= '0;
      end
    end else if (fire && cap_wr && cap_addr_ok) begin
      for (int i = 0; i < SUBWORDS; i++) begin
        if (cap_strb[i]) mem[mem_idx][i] <= (mem[mem_idx][i] & ~cap_biten) | (cap_data & cap_biten);
      end
    end
  end

endmodule

// File: tb/tb_external_mem_responder.sv
// Bench for external_mem_responder. Two instances: dut0 has a fixed zero delay
// and one lane; dut1 has four lanes, DEPTH=12 and a delay of 1..3 cycles.
// Expected responses go onto a per-instance queue when a request is driven and
// are popped when the ack appears. Expected delays come from a bench LFSR model.
module tb_external_mem_responder;

  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // dut0: WIDTH 32, SUBWORDS 1, DEPTH 16, MIN=MAX=0
  logic        rst0, req0, wr0, rd_ack0, wr_ack0, busy0, perr0;
  logic [3:0]  addr0;
  logic [31:0] wdata0, biten0, rd_data0;

  // dut1: WIDTH 32, SUBWORDS 4, DEPTH 12, MIN 1, MAX 3
  logic        rst1, wr1, rd_ack1, wr_ack1, busy1, perr1;
  logic [3:0]  req1, addr1;
  logic [31:0] wdata1, biten1, rd_data1;

  external_mem_responder #(.WIDTH(32), .SUBWORDS(1), .DEPTH(16), .MIN_DELAY(0),
                           .MAX_DELAY(0), .LFSR_SEED(SEED)) dut0 (
    .clk(clk), .rst(rst0), .req(req0), .req_addr(addr0), .req_is_wr(wr0),
    .wr_data(wdata0), .wr_biten(biten0), .rd_ack(rd_ack0), .rd_data(rd_data0),
    .wr_ack(wr_ack0), .busy(busy0), .proto_err(perr0));

  external_mem_responder #(.WIDTH(32), .SUBWORDS(4), .DEPTH(12), .MIN_DELAY(1),
                           .MAX_DELAY(3), .LFSR_SEED(SEED)) dut1 (
    .clk(clk), .rst(rst1), .req(req1), .req_addr(addr1), .req_is_wr(wr1),
    .wr_data(wdata1), .wr_biten(biten1), .rd_ack(rd_ack1), .rd_data(rd_data1),
    .wr_ack(wr_ack1), .busy(busy1), .proto_err(perr1));

  typedef struct {
    logic        is_wr;
    logic [31:0] data;
    int          lat;
  } exp_t;

  exp_t        sb0[$];
  exp_t        sb1[$];
  logic [31:0] m0 [16];
  logic [31:0] m1 [16][4];
  logic [15:0] lfsr_m;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [31:0] be);
    return (old & ~be) | (d & be);
  endfunction

  // ---------------- dut0 helpers ----------------
  task automatic send0(input logic [3:0] a, input logic w, input logic [31:0] d,
                       input logic [31:0] be);
    exp_t e;
    e.is_wr = w;
    e.lat   = 2;
    if (w) begin
      m0[a]  = merge(m0[a], d, be);
      e.data = '0;
    end else begin
      e.data = m0[a];
    end
    sb0.push_back(e);
    req0 = 1'b1; addr0 = a; wr0 = w; wdata0 = d; biten0 = be;
    @(negedge clk);
    req0 = 1'b0;
  endtask

  task automatic wait_ack0(input string tag);
    int   k;
    exp_t e;
    k = 0;
    while (!(rd_ack0 || wr_ack0) && k < 12) begin
      check({tag, "_busy"}, busy0, 1'b1);
      @(negedge clk);
      k++;
    end
    check({tag, "_ack_seen"}, 32'(k < 12), 32'd1);
    if (k < 12) begin
      e = sb0.pop_front();
      check({tag, "_latency"}, k + 1, e.lat);
      check({tag, "_wr_ack"}, wr_ack0, e.is_wr);
      check({tag, "_rd_ack"}, rd_ack0, !e.is_wr);
      check({tag, "_rd_data"}, rd_data0, e.data);
    end
  endtask

  // ---------------- dut1 helpers ----------------
  task automatic send1(input logic [3:0] s, input logic [3:0] a, input logic w,
                       input logic [31:0] d, input logic [31:0] be);
    exp_t e;
    int   lane;
    e.is_wr = w;
    e.lat   = 1 + int'(lfsr_m[7:0]) % 3 + 2;
    lfsr_m  = lfsr_step(lfsr_m);
    e.data  = '0;
    if (w) begin
      if (a < 12) begin
        for (int i = 0; i < 4; i++) if (s[i]) m1[a][i] = merge(m1[a][i], d, be);
      end
    end else if (a < 12) begin
      lane = 0;
      for (int i = 0; i < 4; i++) if (s[i]) lane = i;
      e.data = m1[a][lane];
    end
    sb1.push_back(e);
    req1 = s; addr1 = a; wr1 = w; wdata1 = d; biten1 = be;
    @(negedge clk);
    req1 = '0;
  endtask

  task automatic wait_ack1(input string tag, input int k0);
    int   k;
    exp_t e;
    k = k0;
    while (!(rd_ack1 || wr_ack1) && k < 12) begin
      check({tag, "_busy"}, busy1, 1'b1);
      @(negedge clk);
      k++;
    end
    check({tag, "_ack_seen"}, 32'(k < 12), 32'd1);
    if (k < 12) begin
      e = sb1.pop_front();
      check({tag, "_latency"}, k + 1, e.lat);
      check({tag, "_wr_ack"}, wr_ack1, e.is_wr);
      check({tag, "_rd_ack"}, rd_ack1, !e.is_wr);
      check({tag, "_rd_data"}, rd_data1, e.data);
      check({tag, "_busy_at_ack"}, busy1, 1'b0);
    end
  endtask

  task automatic reset1_model();
    sb1.delete();
    lfsr_m = SEED;
    for (int a = 0; a < 16; a++) for (int i = 0; i < 4; i++) m1[a][i] = '0;
  endtask

  task automatic check_idle1(input string tag);
    check({tag, "_rd_ack"}, rd_ack1, 1'b0);
    check({tag, "_wr_ack"}, wr_ack1, 1'b0);
    check({tag, "_rd_data"}, rd_data1, '0);
    check({tag, "_busy"}, busy1, 1'b0);
  endtask

  initial begin
    int          acks;
    logic [3:0]  s, a;
    logic        w;
    logic [31:0] d, be;

    rst0 = 1'b0; req0 = 1'b0; addr0 = '0; wr0 = 1'b0; wdata0 = '0; biten0 = '0;
    rst1 = 1'b0; req1 = '0;   addr1 = '0; wr1 = 1'b0; wdata1 = '0; biten1 = '0;
    for (int i = 0; i < 16; i++) m0[i] = '0;
    reset1_model();
    repeat (3) @(negedge clk);
    rst0 = 1'b1; rst1 = 1'b1;

    // Reset state of both instances
    check("rst0_rd_ack", rd_ack0, 1'b0);
    check("rst0_wr_ack", wr_ack0, 1'b0);
    check("rst0_rd_data", rd_data0, '0);
    check("rst0_busy", busy0, 1'b0);
    check("rst0_perr", perr0, 1'b0);
    check_idle1("rst1");
    check("rst1_perr", perr1, 1'b0);

    // Fixed zero delay: full write, then read back
    send0(4'd3, 1'b1, 32'hDEADBEEF, 32'hFFFFFFFF);
    wait_ack0("t1_wr");
    @(negedge clk);
    check("t1_ack_pulse", 32'({rd_ack0, wr_ack0}), 32'd0);
    send0(4'd3, 1'b0, '0, '0);
    wait_ack0("t1_rd");
    check("t1_rd_value", rd_data0, 32'hDEADBEEF);
    @(negedge clk);

    // Partial bit enables
    send0(4'd7, 1'b1, 32'hAAAAAAAA, 32'hFFFFFFFF);
    wait_ack0("t2_wr_full");
    @(negedge clk);
    send0(4'd7, 1'b1, 32'h12345678, 32'h0000FFFF);
    wait_ack0("t2_wr_half");
    @(negedge clk);
    send0(4'd7, 1'b0, '0, '0);
    wait_ack0("t2_rd");
    check("t2_rd_value", rd_data0, 32'hAAAA5678);
    check("t2_perr", perr0, 1'b0);
    @(negedge clk);

    // Lane strobes
    send1(4'b0100, 4'd2, 1'b1, 32'h55, 32'hFFFFFFFF);
    wait_ack1("t3_wr", 0);
    @(negedge clk);
    send1(4'b0100, 4'd2, 1'b0, '0, '0);
    wait_ack1("t3_rd_lane2", 0);
    check("t3_rd_lane2_value", rd_data1, 32'h55);
    @(negedge clk);
    send1(4'b0010, 4'd2, 1'b0, '0, '0);
    wait_ack1("t3_rd_lane1", 0);
    check("t3_rd_lane1_value", rd_data1, 32'h0);
    check("t3_perr", perr1, 1'b0);
    @(negedge clk);

    // Out-of-range read
    send1(4'b0001, 4'd13, 1'b0, '0, '0);
    wait_ack1("t6_oor", 0);
    check("t6_oor_perr", perr1, 1'b1);
    @(negedge clk);

    // Back-to-back: new request driven in the ack (RESP) cycle
    send1(4'b1000, 4'd5, 1'b1, 32'hCAFE0001, 32'hFFFFFFFF);
    wait_ack1("t6_b2b_wr", 0);
    send1(4'b1000, 4'd5, 1'b0, '0, '0);
    wait_ack1("t6_b2b_rd", 0);
    check("t6_b2b_value", rd_data1, 32'hCAFE0001);
    @(negedge clk);

    // Full reset clears the sticky flag and the memory
    rst1 = 1'b0;
    @(negedge clk);
    rst1 = 1'b1;
    reset1_model();
    check_idle1("rst1b");
    check("rst1b_perr", perr1, 1'b0);

    // Overlap: second request during WAIT is dropped
    send1(4'b0001, 4'd1, 1'b1, 32'h11, 32'hFFFFFFFF);
    req1 = 4'b0010; addr1 = 4'd2; wr1 = 1'b1; wdata1 = 32'h22; biten1 = '1;
    @(negedge clk);
    req1 = '0;
    wait_ack1("t5_overlap", 1);
    acks = 0;
    repeat (8) begin
      @(negedge clk);
      if (rd_ack1 || wr_ack1) acks++;
    end
    check("t5_extra_acks", acks, 0);
    check("t5_perr", perr1, 1'b1);
    send1(4'b0010, 4'd2, 1'b0, '0, '0);
    wait_ack1("t5_dropped_rd", 0);
    check("t5_dropped_value", rd_data1, 32'h0);
    @(negedge clk);

    // Reset asserted mid-WAIT: pending request vanishes
    send1(4'b0001, 4'd4, 1'b1, 32'h44, 32'hFFFFFFFF);
    check("t5_midwait_busy", busy1, 1'b1);
    rst1 = 1'b0;
    @(negedge clk);
    rst1 = 1'b1;
    reset1_model();
    acks = 0;
    repeat (8) begin
      if (rd_ack1 || wr_ack1) acks++;
      @(negedge clk);
    end
    check("t5_rst_no_ack", acks, 0);
    check_idle1("t5_rst");
    check("t5_rst_perr", perr1, 1'b0);
    send1(4'b0001, 4'd1, 1'b0, '0, '0);
    wait_ack1("t5_rst_rd", 0);
    check("t5_rst_rd_value", rd_data1, 32'h0);
    @(negedge clk);

    // Random traffic, with and without back-to-back issue
    for (int n = 0; n < 1000; n++) begin
      s  = 4'($urandom_range(1, 15));
      a  = 4'($urandom_range(0, 15));
      w  = 1'($urandom_range(0, 1));
      d  = $urandom;
      be = ($urandom_range(0, 1) != 0) ? 32'hFFFFFFFF : $urandom;
      send1(s, a, w, d, be);
      wait_ack1("rnd", 0);
      if ($urandom_range(0, 2) != 0) begin
        @(negedge clk);
        check("rnd_ack_pulse", 32'({rd_ack1, wr_ack1}), 32'd0);
        check("rnd_idle_rd_data", rd_data1, 32'h0);
      end
    end
    check("sb0_empty", sb0.size(), 0);
    check("sb1_empty", sb1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
